// File: rtl/spi_regfile_pkg.sv
// Shared definitions for the SPI register file: FSM state encoding and
// the position of the read/write flag inside a frame.
package spi_regfile_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_WR_DATA,
    ST_RD_DATA,
    ST_DONE
  } state_t;

  localparam logic RW_WRITE = 1'b1;

  // The R/W flag is the frame MSB, i.e. it sits above address and data.
  function automatic int unsigned rw_bit_pos(input int unsigned addr_w,
                                             input int unsigned data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_regfile_sync2.sv
// Two-flop synchronizer bringing one asynchronous SPI line into the clk domain.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_regfile.sv
// SPI mode-0 slave giving serial write/read access to a small register file,
// fully oversampled in the clk domain.
module spi_regfile
  import spi_regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = 5,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         sdi,
  input  logic                         cs,
  output logic                         sdo,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  output logic                         wr_valid,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);

  localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
  localparam int unsigned RW_POS  = rw_bit_pos(ADDR_W, DATA_W);

  localparam logic [CNT_W-1:0]  CNT_HDR    = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]  CNT_FRAME  = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(FRAME_W + 1);
  localparam logic [ADDR_W:0]   NUM_REGS_A = (ADDR_W + 1)'(NUM_REGS);

  logic sclk_s, sdi_s, cs_s;
  logic sclk_d, cs_d;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_t state_q, state_d;

  logic [FRAME_W-1:0] shift_q, next_shift;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  rd_shift_q, rd_word;
  logic [DATA_W-1:0]  regs [NUM_REGS];

  logic [ADDR_W-1:0]  hdr_addr, done_addr;
  logic [DATA_W-1:0]  done_data;
  logic               done_rw, done_in_range;

  sync2 u_sync_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
  sync2 u_sync_sdi  (.clk(clk), .rst(rst), .d(sdi),  .q(sdi_s));
  sync2 u_sync_cs   (.clk(clk), .rst(rst), .d(cs),   .q(cs_s));

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  assign next_shift = {shift_q[FRAME_W-2:0], sdi_s};
  assign hdr_addr   = next_shift[ADDR_W-1:0];

  // A complete frame leaves R/W, address and data in their frame positions.
  assign done_rw       = shift_q[RW_POS];
  assign done_addr     = shift_q[DATA_W +: ADDR_W];
  assign done_data     = shift_q[DATA_W-1:0];
  assign done_in_range = ({1'b0, done_addr} < NUM_REGS_A);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_W +: DATA_W] = regs[g];
  end

  always_comb begin
    rd_word = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (hdr_addr == ADDR_W'(r)) rd_word = regs[r];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) state_d = ST_HDR;
      end
      ST_HDR: begin
        if (cs_rise) begin
          state_d = ST_DONE;
        end else if (sclk_rise && cnt_q == CNT_HDR) begin
          state_d = (next_shift[ADDR_W] == RW_WRITE) ? ST_WR_DATA : ST_RD_DATA;
        end
      end
      ST_WR_DATA, ST_RD_DATA: begin
        if (cs_rise) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_d     <= 1'b0;
      cs_d       <= 1'b0;
      shift_q    <= '0;
      cnt_q      <= '0;
      rd_shift_q <= '0;
      sdo        <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      frame_err  <= 1'b0;
      for (int unsigned r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            shift_q <= '0;
            cnt_q   <= '0;
          end
        end
        ST_HDR, ST_WR_DATA, ST_RD_DATA: begin
          if (sclk_rise && !cs_rise) begin
            shift_q <= next_shift;
            if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (cnt_q != CNT_FRAME) begin
            frame_err <= 1'b1;
          end else if (done_rw == RW_WRITE) begin
            if (done_in_range) begin
              for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (done_addr == ADDR_W'(r)) regs[r] <= done_data;
              end
              wr_valid <= 1'b1;
              wr_addr  <= done_addr;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase

      // Read data is captured as the header completes, then shifted on sclk falls.
      if (state_q == ST_HDR && state_d == ST_RD_DATA) begin
        rd_shift_q <= rd_word;
      end else if (state_q == ST_RD_DATA && sclk_fall && !cs_rise) begin
        rd_shift_q <= {rd_shift_q[DATA_W-2:0], 1'b0};
      end

      if (state_d != ST_RD_DATA) begin
        sdo <= 1'b0;
      end else if (state_q == ST_RD_DATA && sclk_fall) begin
        sdo <= rd_shift_q[DATA_W-1];
      end
    end
  end

endmodule

// File: tb/tb_spi_regfile.sv
// Directed scoreboard bench for spi_regfile: default instance plus a wide
// 8x16 instance sharing sclk/sdi, each with its own chip select.
module tb_spi_regfile;

  logic clk = 1'b0;
  logic rst, sclk, sdi, cs_a, cs_b;

  logic         sdo_a, wr_valid_a, frame_err_a;
  logic [39:0]  reg_out_a;
  logic [6:0]   wr_addr_a;
  logic         sdo_b, wr_valid_b, frame_err_b;
  logic [127:0] reg_out_b;
  logic [6:0]   wr_addr_b;

  always #5 clk = ~clk;

  spi_regfile u_dut_a (
    .clk(clk), .rst(rst), .sclk(sclk), .sdi(sdi), .cs(cs_a),
    .sdo(sdo_a), .reg_out(reg_out_a), .wr_valid(wr_valid_a),
    .wr_addr(wr_addr_a), .frame_err(frame_err_a)
  );

  spi_regfile #(.NUM_REGS(8), .DATA_W(16), .ADDR_W(7)) u_dut_b (
    .clk(clk), .rst(rst), .sclk(sclk), .sdi(sdi), .cs(cs_b),
    .sdo(sdo_b), .reg_out(reg_out_b), .wr_valid(wr_valid_b),
    .wr_addr(wr_addr_b), .frame_err(frame_err_b)
  );

  typedef struct packed {
    logic       err;
    logic [6:0] addr;
  } evt_t;

  evt_t        sb_a[$];
  evt_t        sb_b[$];
  logic [15:0] rd_sb[$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [7:0]  model_a[5];
  logic [15:0] model_b[8];
  logic [15:0] rd;
  logic        hdr;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    evt_t ev;
    if (!rst && (wr_valid_a || frame_err_a)) begin
      if (sb_a.size() == 0) begin
        check("unexpected_evt_a", {wr_valid_a, frame_err_a}, 2'b00);
      end else begin
        ev = sb_a.pop_front();
        check("frame_err_a", frame_err_a, ev.err);
        check("wr_valid_a", wr_valid_a, !ev.err);
        if (!ev.err) check("wr_addr_a", wr_addr_a, ev.addr);
      end
    end
  end

  always @(negedge clk) begin
    evt_t ev;
    if (!rst && (wr_valid_b || frame_err_b)) begin
      if (sb_b.size() == 0) begin
        check("unexpected_evt_b", {wr_valid_b, frame_err_b}, 2'b00);
      end else begin
        ev = sb_b.pop_front();
        check("frame_err_b", frame_err_b, ev.err);
        check("wr_valid_b", wr_valid_b, !ev.err);
        if (!ev.err) check("wr_addr_b", wr_addr_b, ev.addr);
      end
    end
  end

  // Shifts value[nbits-1:0] MSB first; sdo is sampled just before each rise.
  task automatic spi_bits(input bit sel, input int nbits, input logic [31:0] value,
                          output logic [15:0] rdv, output logic hdr_sdo);
    logic s;
    rdv     = '0;
    hdr_sdo = 1'b0;
    for (int k = nbits - 1; k >= 0; k--) begin
      sdi = value[k];
      #40;
      s = sel ? sdo_b : sdo_a;
      if (nbits - 1 - k >= 8) rdv = {rdv[14:0], s};
      else                    hdr_sdo = hdr_sdo | s;
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input bit sel, input int nbits, input logic [31:0] value,
                       output logic [15:0] rdv, output logic hdr_sdo);
    @(negedge clk);
    if (sel) cs_b = 1'b0; else cs_a = 1'b0;
    #40;
    spi_bits(sel, nbits, value, rdv, hdr_sdo);
    #40;
    if (sel) cs_b = 1'b1; else cs_a = 1'b1;
    #40;
  endtask

  task automatic drain();
    repeat (12) @(negedge clk);
    check("sb_a_drain", sb_a.size(), 0);
    check("sb_b_drain", sb_b.size(), 0);
  endtask

  task automatic check_regs();
    logic [127:0] ea, eb;
    ea = '0;
    eb = '0;
    for (int r = 0; r < 5; r++) ea[r*8 +: 8] = model_a[r];
    for (int r = 0; r < 8; r++) eb[r*16 +: 16] = model_b[r];
    check("reg_out_a", reg_out_a, ea);
    check("reg_out_b", reg_out_b, eb);
  endtask

  initial begin
    rst  = 1'b1;
    sclk = 1'b0;
    sdi  = 1'b0;
    cs_a = 1'b1;
    cs_b = 1'b1;
    for (int r = 0; r < 5; r++) model_a[r] = '0;
    for (int r = 0; r < 8; r++) model_b[r] = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_reg_out_a", reg_out_a, 0);
    check("rst_reg_out_b", reg_out_b, 0);
    check("rst_wr_valid_a", wr_valid_a, 0);
    check("rst_frame_err_a", frame_err_a, 0);
    check("rst_wr_addr_a", wr_addr_a, 0);
    check("rst_sdo_a", sdo_a, 0);

    // Write 0xA5 to addr 2
    sb_a.push_back({1'b0, 7'd2});
    model_a[2] = 8'hA5;
    frame(0, 16, 32'h82A5, rd, hdr);
    check("wr_hdr_sdo", hdr, 0);
    drain();
    check_regs();

    // Read addr 2
    rd_sb.push_back(16'h00A5);
    frame(0, 16, 32'h0200, rd, hdr);
    check("rd_addr2", rd, rd_sb.pop_front());
    check("rd_hdr_sdo", hdr, 0);
    drain();
    check_regs();

    // Out-of-range write
    sb_a.push_back({1'b1, 7'd0});
    frame(0, 16, 32'h8711, rd, hdr);
    drain();
    check_regs();

    // Short and long write frames to addr 0
    sb_a.push_back({1'b1, 7'd0});
    frame(0, 15, 32'h4019, rd, hdr);
    drain();
    sb_a.push_back({1'b1, 7'd0});
    frame(0, 17, 32'h10067, rd, hdr);
    drain();
    check_regs();

    // Valid write addr 0, read back, out-of-range read, short read
    sb_a.push_back({1'b0, 7'd0});
    model_a[0] = 8'h5A;
    frame(0, 16, 32'h805A, rd, hdr);
    drain();
    rd_sb.push_back(16'h005A);
    frame(0, 16, 32'h0000, rd, hdr);
    check("rd_addr0", rd, rd_sb.pop_front());
    rd_sb.push_back(16'h0000);
    frame(0, 16, 32'h0500, rd, hdr);
    check("rd_addr5_zero", rd, rd_sb.pop_front());
    sb_a.push_back({1'b1, 7'd0});
    frame(0, 10, 32'h0000, rd, hdr);
    drain();
    check_regs();

    // Reset after 9 bits of a write with cs held low: no commit, no error
    @(negedge clk);
    cs_a = 1'b0;
    #40;
    spi_bits(0, 9, 32'h0102, rd, hdr);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    cs_a = 1'b1;
    for (int r = 0; r < 5; r++) model_a[r] = '0;
    drain();
    check_regs();
    sb_a.push_back({1'b0, 7'd1});
    model_a[1] = 8'h33;
    frame(0, 16, 32'h8133, rd, hdr);
    drain();
    check_regs();

    // Wide instance: 0xBEEF to addr 7 and read back
    sb_b.push_back({1'b0, 7'd7});
    model_b[7] = 16'hBEEF;
    frame(1, 24, 32'h0087BEEF, rd, hdr);
    drain();
    check_regs();
    rd_sb.push_back(16'hBEEF);
    frame(1, 24, 32'h00070000, rd, hdr);
    check("rd_b_addr7", rd, rd_sb.pop_front());
    check("rd_b_hdr_sdo", hdr, 0);
    drain();
    check_regs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_regfile.md
SPI_REGFILE -- requirements
Module: spi_regfile

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 5, meaning the number of writable/readable registers.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the register width in bits.
REQ-003 The block SHALL have parameter ADDR_W, default 7, meaning the address field width; FRAME_W = 1+ADDR_W+DATA_W (default 16).
REQ-004 Port clk, input, 1 bit: single system clock; all logic SHALL be on posedge clk.
REQ-005 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 Port sclk, input, 1 bit: SPI clock, asynchronous to clk, mode 0 (CPOL=0, CPHA=0).
REQ-007 Port sdi, input, 1 bit: serial data in, MSB first.
REQ-008 Port cs, input, 1 bit: chip select, active-low.
REQ-009 Port sdo, output, 1 bit: serial data out for reads.
REQ-010 Port reg_out, output, NUM_REGS*DATA_W bits: register r at bits [r*DATA_W +: DATA_W].
REQ-011 Port wr_valid, output, 1 bit: one-cycle pulse on each committed write.
REQ-012 Port wr_addr, output, ADDR_W bits: address of the last committed write, valid with wr_valid.
REQ-013 Port frame_err, output, 1 bit: one-cycle pulse when a frame is discarded.

Function
REQ-014 sclk, sdi and cs SHALL each pass through a 2-flop synchronizer; sclk edges SHALL be detected on synchronized values; supported sclk <= clk/4.
REQ-015 Frame format: bit FRAME_W-1 = R/W (1 = write, 0 = read), then ADDR_W address bits, then DATA_W data bits, all MSB first.
REQ-016 States: IDLE, HDR (shifting R/W+address), WR_DATA, RD_DATA, DONE.
REQ-017 IDLE->HDR only on a synchronized cs falling edge; cs low without an observed falling edge SHALL NOT start a frame.
REQ-018 In HDR/WR_DATA/RD_DATA, sdi SHALL be sampled on each synchronized sclk rising edge; bit counter saturates at FRAME_W+1.
REQ-019 After the last address bit: HDR->WR_DATA if R/W=1, HDR->RD_DATA if R/W=0.
REQ-020 In RD_DATA, sdo SHALL present register[addr] MSB at the first synchronized sclk falling edge after the last address bit, shifting one bit per subsequent falling edge.
REQ-021 Reads of address >= NUM_REGS SHALL return all zeros; a read SHALL NOT change any register or pulse wr_valid.
REQ-022 sdo SHALL be 0 in IDLE, HDR, WR_DATA and DONE.
REQ-023 On a synchronized cs rising edge in any non-IDLE state, the FSM SHALL go to DONE; sclk edges in that same cycle SHALL be ignored.
REQ-024 In DONE, a write SHALL commit iff bit count == FRAME_W, R/W=1 and addr < NUM_REGS: in the next cycle reg_out slice is updated, wr_valid=1, wr_addr=addr.
REQ-025 A write frame with bit count != FRAME_W, or addr >= NUM_REGS, SHALL be discarded with a frame_err pulse in that cycle; a read frame with bit count != FRAME_W SHALL also pulse frame_err.
REQ-026 DONE SHALL return to IDLE after exactly one cycle.
REQ-027 A synchronized cs rising edge in IDLE SHALL be ignored.

Reset
REQ-028 While rst=1 on a clk edge: all reg_out slices, wr_valid, wr_addr, frame_err, sdo, shift register and bit counter SHALL become 0 and FSM SHALL become IDLE.
REQ-029 Synchronizer flops SHALL reset to 0 for sclk/sdi and 0 for cs, so cs held low across reset does not start a frame.
REQ-030 Reset mid-frame SHALL abort the frame with no commit and no frame_err pulse.

Structure
REQ-031 A shared package SHALL hold the FSM state enum and the R/W bit-position constant.
REQ-032 The 2-flop synchronizer SHALL be one sub-module, sync2, instantiated three times.

Verification
REQ-033 Write frame 0x82A5 (defaults) -> one cycle after synced cs rise, reg_out[23:16]=0xA5, wr_valid pulse, wr_addr=2.
REQ-034 After REQ-033, read frame 0x0200 -> sdo shifts 0xA5 MSB first in data phase; no register change.
REQ-035 Write frame 0x8711 (addr 7) -> frame_err pulse, reg_out unchanged.
REQ-036 15-bit and 17-bit write frames to addr 0 -> frame_err pulse each, reg_out[7:0] unchanged.
REQ-037 rst asserted after 9 bits of a write frame, cs held low -> no commit; the next cs high->low frame commits correctly.
REQ-038 NUM_REGS=8, DATA_W=16: write 0xBEEF to addr 7 then read back -> reg_out[127:112]=0xBEEF, sdo returns 0xBEEF.
